// File: rtl/fp16_multiplier.sv
// Sequential IEEE-754 half-precision multiplier: shift-add significand product (one bit per clock),
// then a single normalize/round-to-nearest-even cycle. Fixed 12-clock latency, no back-pressure.
module fp16_multiplier (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] Y,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {StIdle, StMul, StNorm} state_t;

    state_t             state_q;
    logic               sign_q;
    logic signed [6:0]  exp_q;
    logic [21:0]        mcand_q;
    logic [10:0]        mplier_q;
    logic [21:0]        p_q;
    logic [3:0]         cnt_q;
    logic               special_q;
    logic [15:0]        special_y_q;

    // Operand classification (subnormals count as zero).
    logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, sign_in;
    logic               special_in;
    logic [15:0]        special_y_in;
    logic signed [6:0]  exp_sum;
    logic               accept;

    always_comb begin
        sign_in = A[15] ^ B[15];
        a_zero  = (A[14:10] == 5'd0);
        b_zero  = (B[14:10] == 5'd0);
        a_inf   = (A[14:10] == 5'h1F) && (A[9:0] == 10'd0);
        b_inf   = (B[14:10] == 5'h1F) && (B[9:0] == 10'd0);
        a_nan   = (A[14:10] == 5'h1F) && (A[9:0] != 10'd0);
        b_nan   = (B[14:10] == 5'h1F) && (B[9:0] != 10'd0);
        special_in   = 1'b1;
        special_y_in = 16'h0000;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            special_y_in = 16'h7E00;
        end else if (a_inf || b_inf) begin
            special_y_in = {sign_in, 5'h1F, 10'h000};
        end else if (a_zero || b_zero) begin
            special_y_in = {sign_in, 15'h0000};
        end else begin
            special_in = 1'b0;
        end
        exp_sum = $signed({2'b00, A[14:10]}) + $signed({2'b00, B[14:10]}) - 7'sd15;
        // The NORM edge may also accept the next pair so start held high yields a 12-cycle cadence.
        accept  = start && ((state_q == StIdle) || (state_q == StNorm));
    end

    // Normalize and round the finished product.
    logic [9:0]         mant;
    logic               guard, sticky, round_up;
    logic [10:0]        mant_r;
    logic [9:0]         mant_f;
    logic signed [6:0]  exp_n, exp_r;
    logic [15:0]        y_next;

    always_comb begin
        if (p_q[21]) begin
            mant   = p_q[20:11];
            guard  = p_q[10];
            sticky = |p_q[9:0];
            exp_n  = exp_q + 7'sd1;
        end else begin
            mant   = p_q[19:10];
            guard  = p_q[9];
            sticky = |p_q[8:0];
            exp_n  = exp_q;
        end
        round_up = guard && (sticky || mant[0]);
        mant_r   = {1'b0, mant} + {10'd0, round_up};
        if (mant_r[10]) begin
            mant_f = 10'd0;
            exp_r  = exp_n + 7'sd1;
        end else begin
            mant_f = mant_r[9:0];
            exp_r  = exp_n;
        end
        if (special_q) begin
            y_next = special_y_q;
        end else if (exp_r >= 7'sd31) begin
            y_next = {sign_q, 5'h1F, 10'h000};
        end else if (exp_r <= 7'sd0) begin
            y_next = {sign_q, 15'h0000};
        end else begin
            y_next = {sign_q, exp_r[4:0], mant_f};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            Y           <= 16'h0000;
            busy        <= 1'b0;
            done        <= 1'b0;
            cnt_q       <= 4'd0;
            sign_q      <= 1'b0;
            exp_q       <= 7'sd0;
            mcand_q     <= 22'd0;
            mplier_q    <= 11'd0;
            p_q         <= 22'd0;
            special_q   <= 1'b0;
            special_y_q <= 16'h0000;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: ;
                StMul: begin
                    if (mplier_q[0]) p_q <= p_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 4'd1;
                    if (cnt_q == 4'd10) state_q <= StNorm;
                end
                StNorm: begin
                    Y       <= y_next;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
            if (accept) begin
                state_q     <= StMul;
                busy        <= 1'b1;
                cnt_q       <= 4'd0;
                sign_q      <= sign_in;
                exp_q       <= exp_sum;
                mcand_q     <= {11'd0, 1'b1, A[9:0]};
                mplier_q    <= {1'b1, B[9:0]};
                p_q         <= 22'd0;
                special_q   <= special_in;
                special_y_q <= special_y_in;
            end
        end
    end

endmodule
